// File: rtl/ram_loader.sv
// UART (8N1) byte receiver that pairs bytes big-endian into 16-bit words and
// writes them to consecutive RAM addresses, wrapping after DEPTH words.
module ram_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    input  logic        clear,
    output logic [15:0] ram_in,
    output logic [15:0] ram_address,
    output logic        ram_load,
    output logic        busy,
    output logic        frame_err
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          rx_meta;
    logic          rx_sync;
    logic [15:0]   cnt;
    logic [15:0]   cnt_nx;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_nx;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nx;
    logic          byte_done;
    logic          byte_bad;
    logic          phase_lo;
    logic [7:0]    hi_byte;
    logic [PW-1:0] ptr;

    // Synchronizer idles high so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + 16'd1;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        byte_done  = 1'b0;
        byte_bad   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!rx_sync) begin
                    state_nx   = START;
                    bit_cnt_nx = '0;
                end
            end
            START: begin
                // Mid-start-bit check; a high line here was only a glitch.
                if (cnt == HALF_M1) begin
                    cnt_nx   = '0;
                    state_nx = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_nx     = '0;
                    shreg_nx   = {rx_sync, shreg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    if (rx_sync) begin
                        byte_done = 1'b1;
                    end else begin
                        byte_bad = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Clear takes priority over any byte completing on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            phase_lo  <= 1'b0;
            hi_byte   <= '0;
            ram_in    <= '0;
            ram_load  <= 1'b0;
            frame_err <= 1'b0;
        end else if (clear) begin
            ptr       <= '0;
            phase_lo  <= 1'b0;
            ram_load  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ram_load <= 1'b0;
            if (ram_load) begin
                ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            end
            if (byte_bad) begin
                frame_err <= 1'b1;
                phase_lo  <= 1'b0;
            end else if (byte_done) begin
                if (!phase_lo) begin
                    hi_byte  <= shreg;
                    phase_lo <= 1'b1;
                end else begin
                    ram_in   <= {hi_byte, shreg};
                    ram_load <= 1'b1;
                    phase_lo <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        ram_address         = '0;
        ram_address[PW-1:0] = ptr;
    end

endmodule
